// File: rtl/clock_freq_monitor.sv
// Crypto-clock frequency monitor: counts synchronized rising edges of I_clk_sample over a
// fixed usb_clk gate window and flags a stopped clock.
module clock_freq_monitor #(
  parameter int unsigned GATE_CYCLES = 96000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STOP_CYCLES = 255
) (
  input  logic             usb_clk,
  input  logic             reset,
  input  logic             I_clk_sample,
  input  logic             I_enable,
  output logic [CNT_W-1:0] O_freq_count,
  output logic             O_freq_valid,
  output logic             O_freq_update,
  output logic             O_freq_overflow,
  output logic             O_clk_stopped
);

  localparam int unsigned GateW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned IdleW = $clog2(STOP_CYCLES + 1);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(STOP_CYCLES);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic [GateW-1:0] gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_cnt_inc;
  logic             sat_q, sat_d, sat_inc, lost;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d, upd_q, upd_d, ovf_q, ovf_d;

  assign edge_det = s2_q & ~s3_q;

  // An edge arriving while the counter is all-ones is lost; that is what marks saturation.
  assign lost         = edge_det & (edge_cnt_q == CntMax);
  assign edge_cnt_inc = lost ? edge_cnt_q : edge_cnt_q + CNT_W'(edge_det);
  assign sat_inc      = sat_q | lost;

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    idle_d     = idle_q;
    count_d    = count_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    upd_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        idle_d     = '0;
        if (I_enable) state_d = StMeasure;
      end
      StMeasure: begin
        if (!I_enable) begin
          state_d    = StIdle;
          gate_d     = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          idle_d     = '0;
        end else begin
          if (edge_det)               idle_d = '0;
          else if (idle_q != IdleMax) idle_d = idle_q + IdleW'(1);
          if (gate_q == GateLast) begin
            count_d    = edge_cnt_inc;
            ovf_d      = sat_inc;
            valid_d    = 1'b1;
            upd_d      = 1'b1;
            gate_d     = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
          end else begin
            gate_d     = gate_q + GateW'(1);
            edge_cnt_d = edge_cnt_inc;
            sat_d      = sat_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= StIdle;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      idle_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= I_clk_sample;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      idle_q     <= idle_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign O_freq_count    = count_q;
  assign O_freq_valid    = valid_q;
  assign O_freq_update   = upd_q;
  assign O_freq_overflow = ovf_q;
  assign O_clk_stopped   = (state_q == StMeasure) && (idle_q == IdleMax);

endmodule
